// File: rtl/panda_lsu.sv
// Load-store unit for the Panda RV32I core: one data-memory transaction at a
// time over a req/gnt/rvalid bus, with lane steering and load extension.
module panda_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_busy_o,
    output logic        lsu_done_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_rdata_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID
    } state_t;

    state_t      state_q, state_d;

    logic        we_q;
    logic [1:0]  type_q;
    logic        sign_q;
    logic [1:0]  offset_q;

    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] bus_addr_q;
    logic        bus_we_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;

    logic        req_bad;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] shifted;
    logic [31:0] load_data;

    // Misalignment / illegal-size check on the incoming request.
    always_comb begin
        req_bad = 1'b0;
        case (lsu_type_i)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = lsu_addr_i[0];
            2'b10:   req_bad = |lsu_addr_i[1:0];
            default: req_bad = 1'b1;
        endcase
    end

    // Byte enables and store-data replication across the lanes.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = lsu_wdata_i;
        case (lsu_type_i)
            2'b00: begin
                be_d    = 4'b0001 << lsu_addr_i[1:0];
                wdata_d = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << lsu_addr_i[1:0];
                wdata_d = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = lsu_wdata_i;
            end
        endcase
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted   = data_rdata_i >> {offset_q, 3'b000};
        load_data = shifted;
        case (type_q)
            2'b00:   load_data = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (lsu_req_i && !req_bad) state_d = WAIT_GNT;
            WAIT_GNT:    if (data_gnt_i)            state_d = WAIT_RVALID;
            WAIT_RVALID: if (data_rvalid_i)         state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Request capture and the registered done/err/rdata pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q        <= 1'b0;
            type_q      <= 2'b00;
            sign_q      <= 1'b0;
            offset_q    <= 2'b00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
            bus_addr_q  <= 32'h0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            if (state_q == IDLE && lsu_req_i) begin
                we_q     <= lsu_we_i;
                type_q   <= lsu_type_i;
                sign_q   <= lsu_sign_ext_i;
                offset_q <= lsu_addr_i[1:0];
                if (req_bad) begin
                    done_q <= 1'b1;
                    err_q  <= 1'b1;
                end else begin
                    bus_addr_q  <= {lsu_addr_i[31:2], 2'b00};
                    bus_we_q    <= lsu_we_i;
                    bus_be_q    <= be_d;
                    bus_wdata_q <= wdata_d;
                end
            end
            if (state_q == WAIT_RVALID && data_rvalid_i) begin
                done_q  <= 1'b1;
                err_q   <= data_err_i;
                rdata_q <= (we_q || data_err_i) ? 32'h0 : load_data;
            end
        end
    end

    assign lsu_busy_o   = (state_q != IDLE);
    assign lsu_done_o   = done_q;
    assign lsu_err_o    = err_q;
    assign lsu_rdata_o  = rdata_q;
    assign data_req_o   = (state_q == WAIT_GNT);
    assign data_addr_o  = bus_addr_q;
    assign data_we_o    = bus_we_q;
    assign data_be_o    = bus_be_q;
    assign data_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_panda_lsu.sv
// Directed bench for panda_lsu: a vector table of single accesses plus
// hand-written back-pressure, busy-request and mid-transaction reset sequences.
module tb_panda_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req, lsu_we, lsu_sign_ext;
    logic [1:0]  lsu_type;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        lsu_busy, lsu_done, lsu_err;
    logic [31:0] lsu_rdata;
    logic        data_req, data_gnt, data_we, data_rvalid, data_err;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    panda_lsu dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .lsu_req_i      (lsu_req),
        .lsu_we_i       (lsu_we),
        .lsu_type_i     (lsu_type),
        .lsu_sign_ext_i (lsu_sign_ext),
        .lsu_addr_i     (lsu_addr),
        .lsu_wdata_i    (lsu_wdata),
        .lsu_busy_o     (lsu_busy),
        .lsu_done_o     (lsu_done),
        .lsu_err_o      (lsu_err),
        .lsu_rdata_o    (lsu_rdata),
        .data_req_o     (data_req),
        .data_gnt_i     (data_gnt),
        .data_addr_o    (data_addr),
        .data_we_o      (data_we),
        .data_be_o      (data_be),
        .data_wdata_o   (data_wdata),
        .data_rvalid_i  (data_rvalid),
        .data_rdata_i   (data_rdata),
        .data_err_i     (data_err)
    );

    typedef struct {
        logic        we;
        logic [1:0]  ltype;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_rdata;
        logic        bus_err;
        logic        exp_legal;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        lsu_req      = 1'b1;
        lsu_we       = v.we;
        lsu_type     = v.ltype;
        lsu_sign_ext = v.sext;
        lsu_addr     = v.addr;
        lsu_wdata    = v.wdata;
        step();
        lsu_req = 1'b0;
        if (!v.exp_legal) begin
            checkOutput({p, "_req"},   32'(data_req),  32'h0);
            checkOutput({p, "_busy"},  32'(lsu_busy),  32'h0);
            checkOutput({p, "_done"},  32'(lsu_done),  32'h1);
            checkOutput({p, "_err"},   32'(lsu_err),   32'h1);
            checkOutput({p, "_rdata"}, lsu_rdata,      32'h0);
            step();
            checkOutput({p, "_done_clr"}, 32'(lsu_done), 32'h0);
            checkOutput({p, "_req2"},     32'(data_req), 32'h0);
        end else begin
            checkOutput({p, "_req"},   32'(data_req), 32'h1);
            checkOutput({p, "_busy"},  32'(lsu_busy), 32'h1);
            checkOutput({p, "_done0"}, 32'(lsu_done), 32'h0);
            checkOutput({p, "_addr"},  data_addr,     v.addr & 32'hFFFF_FFFC);
            checkOutput({p, "_we"},    32'(data_we),  32'(v.we));
            checkOutput({p, "_be"},    32'(data_be),  32'(v.exp_be));
            checkOutput({p, "_wdata"}, data_wdata,    v.exp_wdata);
            data_gnt = 1'b1;
            step();
            data_gnt = 1'b0;
            checkOutput({p, "_req_drop"}, 32'(data_req), 32'h0);
            checkOutput({p, "_busy2"},    32'(lsu_busy), 32'h1);
            data_rvalid = 1'b1;
            data_rdata  = v.bus_rdata;
            data_err    = v.bus_err;
            step();
            data_rvalid = 1'b0;
            data_err    = 1'b0;
            checkOutput({p, "_done"},  32'(lsu_done), 32'h1);
            checkOutput({p, "_err"},   32'(lsu_err),  32'(v.exp_err));
            checkOutput({p, "_rdata"}, lsu_rdata,     v.exp_rdata);
            checkOutput({p, "_idle"},  32'(lsu_busy), 32'h0);
            step();
            checkOutput({p, "_done_clr"}, 32'(lsu_done), 32'h0);
        end
    endtask

    initial begin
        //            we    type  sx    addr          wdata         bus_rdata     berr  legal be       exp_wdata     eerr  exp_rdata
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h5555_5555, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h0000_2001, 32'h0000_0000, 32'h8081_F27F, 1'b0, 1'b1, 4'b0010, 32'h0000_0000, 1'b0, 32'hFFFF_FFF2};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0000_2001, 32'h0000_0000, 32'h8081_F27F, 1'b0, 1'b1, 4'b0010, 32'h0000_0000, 1'b0, 32'h0000_00F2};
        vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0000_0000, 32'h8081_F27F, 1'b0, 1'b1, 4'b1100, 32'h0000_0000, 1'b0, 32'hFFFF_8081};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h0000_2000, 32'h0000_0000, 32'h8081_F27F, 1'b0, 1'b1, 4'b0011, 32'h0000_0000, 1'b0, 32'h0000_F27F};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_2000, 32'h0000_0000, 32'h8081_F27F, 1'b0, 1'b1, 4'b1111, 32'h0000_0000, 1'b0, 32'h8081_F27F};
        vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'h0000_3003, 32'h1234_56AB, 32'h0000_0000, 1'b0, 1'b1, 4'b1000, 32'hABAB_ABAB, 1'b0, 32'h0000_0000};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h0000_3002, 32'hFFFF_1234, 32'h0000_0000, 1'b0, 1'b1, 4'b1100, 32'h1234_1234, 1'b0, 32'h0000_0000};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h0000_2002, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h0000_3001, 32'h0000_1234, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h0000_4000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[11] = '{1'b0, 2'd0, 1'b1, 32'h0000_2003, 32'h0000_0000, 32'h7F00_0000, 1'b0, 1'b1, 4'b1000, 32'h0000_0000, 1'b0, 32'h0000_007F};
        vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 4'b1111, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[13] = '{1'b0, 2'd0, 1'b1, 32'h0000_2000, 32'h0000_0000, 32'h0000_0080, 1'b0, 1'b1, 4'b0001, 32'h0000_0000, 1'b0, 32'hFFFF_FF80};

        rst = 1'b1;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_type = 2'd0; lsu_sign_ext = 1'b0;
        lsu_addr = 32'h0; lsu_wdata = 32'h0;
        data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = 32'h0; data_err = 1'b0;
        step();
        step();
        checkOutput("rst_busy",  32'(lsu_busy),  32'h0);
        checkOutput("rst_done",  32'(lsu_done),  32'h0);
        checkOutput("rst_err",   32'(lsu_err),   32'h0);
        checkOutput("rst_rdata", lsu_rdata,      32'h0);
        checkOutput("rst_req",   32'(data_req),  32'h0);
        checkOutput("rst_we",    32'(data_we),   32'h0);
        checkOutput("rst_addr",  data_addr,      32'h0);
        checkOutput("rst_be",    32'(data_be),   32'h0);
        checkOutput("rst_wdata", data_wdata,     32'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 14; i++) applyStimulus(i, vecs[i]);

        // Grant withheld five cycles, with a stray request and stray rvalid.
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_type = 2'd2; lsu_sign_ext = 1'b0;
        lsu_addr = 32'h0000_6008; lsu_wdata = 32'hCAFE_F00D;
        step();
        lsu_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                lsu_req = 1'b1; lsu_we = 1'b0; lsu_type = 2'd0;
                lsu_addr = 32'h0000_7001; lsu_wdata = 32'h0000_0011;
            end else begin
                lsu_req = 1'b0;
            end
            data_rvalid = (c == 3);
            checkOutput($sformatf("bp%0d_req", c),   32'(data_req), 32'h1);
            checkOutput($sformatf("bp%0d_addr", c),  data_addr,     32'h0000_6008);
            checkOutput($sformatf("bp%0d_be", c),    32'(data_be),  32'hF);
            checkOutput($sformatf("bp%0d_wdata", c), data_wdata,    32'hCAFE_F00D);
            checkOutput($sformatf("bp%0d_we", c),    32'(data_we),  32'h1);
            checkOutput($sformatf("bp%0d_done", c),  32'(lsu_done), 32'h0);
            step();
        end
        lsu_req = 1'b0; data_rvalid = 1'b0;
        checkOutput("bp_still_req", 32'(data_req), 32'h1);
        checkOutput("bp_no_done",   32'(lsu_done), 32'h0);
        data_gnt = 1'b1;
        step();
        data_gnt = 1'b0;
        checkOutput("bp_req_drop", 32'(data_req), 32'h0);
        checkOutput("bp_busy",     32'(lsu_busy), 32'h1);
        data_rvalid = 1'b1; data_rdata = 32'h1111_2222;
        step();
        data_rvalid = 1'b0;
        checkOutput("bp_done",  32'(lsu_done), 32'h1);
        checkOutput("bp_err",   32'(lsu_err),  32'h0);
        checkOutput("bp_rdata", lsu_rdata,     32'h0);
        step();
        checkOutput("bp_after_req", 32'(data_req), 32'h0);

        // Reset in WAIT_RVALID, late rvalid, then a normal access.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_type = 2'd2; lsu_addr = 32'h0000_8000;
        step();
        lsu_req = 1'b0;
        data_gnt = 1'b1;
        step();
        data_gnt = 1'b0;
        checkOutput("mr_in_rvalid", 32'(lsu_busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("mr_busy", 32'(lsu_busy), 32'h0);
        checkOutput("mr_req",  32'(data_req), 32'h0);
        checkOutput("mr_done", 32'(lsu_done), 32'h0);
        checkOutput("mr_addr", data_addr,     32'h0);
        checkOutput("mr_be",   32'(data_be),  32'h0);
        data_rvalid = 1'b1; data_rdata = 32'hFFFF_FFFF;
        step();
        data_rvalid = 1'b0;
        checkOutput("mr_late_done",  32'(lsu_done), 32'h0);
        checkOutput("mr_late_rdata", lsu_rdata,     32'h0);
        step();
        checkOutput("mr_late_done2", 32'(lsu_done), 32'h0);
        applyStimulus(100, vecs[3]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
